zed_io_seq: RTL and testbench
=============================

# zed_io_seq

Autonomous AXI4-Lite master that configures and services the board I/O register slave (LEDs, switches, buttons, debounce, interrupts). After reset it programs debounce and interrupt setup and checks the ID register. It then runs a service loop: on interrupt it reads and clears the interrupt status, and optionally mirrors the switch inputs onto the LEDs. It sits between the I/O register slave and the fabric interrupt line, so the processor does not have to manage the I/O block.

## Interface
Parameters:
- DEB_TIME, 5'd10: value written to debounce time register 0x24
- DEB_ENA, 13'h1FFF: value written to debounce enable register 0x20
- EDGE_CFG, 16'h1F1F: value written to edge select register 0x14 (neg in [12:8], pos in [4:0])
- INT_ENA, 13'h1FFF: value written to interrupt enable register 0x0C
- ID_VALUE, 32'h7E8155AA: expected content of ID register 0x28

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset, asynchronous, active-low
- AWVALID  out  1  write address valid
- AWREADY  in  1  write address ready
- AWADDR  out  32  write address
- WVALID  out  1  write data valid
- WREADY  in  1  write data ready
- WDATA  out  32  write data
- WSTRB  out  4  byte strobes, always 4'hF
- BVALID  in  1  write response valid
- BREADY  out  1  write response ready
- BRESP  in  2  write response
- ARVALID  out  1  read address valid
- ARREADY  in  1  read address ready
- ARADDR  out  32  read address
- RVALID  in  1  read data valid
- RREADY  out  1  read data ready
- RDATA  in  32  read data
- RRESP  in  2  read response
- irq  in  1  level interrupt from the I/O block (OR of enabled status bits)
- mirror_en  in  1  enables the switch-to-LED mirror step
- init_done  out  1  high once the init sequence and ID check have passed
- busy  out  1  high whenever the FSM is outside IDLE
- err  out  1  sticky error flag
- evt_valid  out  1  one-cycle pulse per serviced interrupt
- evt_status  out  13  last interrupt status, buttons [12:8], switches [7:0]

PROT is not a port. It is tied to 3'b000 at integration.

## Operation
- Reset values: every output is 0, except WSTRB = 4'hF. The FSM enters INIT_0.
- Init states, one transaction each, in this order:
  - INIT_0: write 0x24 ← DEB_TIME
  - INIT_1: write 0x20 ← DEB_ENA
  - INIT_2: write 0x14 ← EDGE_CFG
  - INIT_3: write 0x0C ← INT_ENA
  - ID_RD: read 0x28
- If RDATA equals ID_VALUE: set init_done and go to IDLE.
- Otherwise: set err and go to FAIL. FAIL is terminal until reset, busy = 1 and init_done = 0.
- Service loop:
  - IDLE samples irq and mirror_en.
  - irq = 1 has priority: ST_RD (read 0x08), then CLR_WR (write 0x08 ← status read), then evt_valid pulse, then back to IDLE.
  - Otherwise, if mirror_en = 1: SW_RD (read 0x04), then LED_WR (write 0x00 ← {24'h0, RDATA[7:0]}), then back to IDLE.
  - irq is re-evaluated only in IDLE. It is never aborted mid-sequence.
- Any BRESP or RRESP other than OKAY sets err. The sequence continues, except during ID_RD.
- Unused RDATA bits are ignored. The status register is latched as RDATA[12:0].

## Timing
- Write: AWVALID and WVALID rise together, in the cycle after the FSM issues the command.
  - Each is held until its READY is sampled high, then dropped in the next cycle.
  - BREADY is asserted from issue until BVALID is sampled high.
  - The transaction completes on BVALID & BREADY.
  - VALID is never withdrawn before READY.
- Read: ARVALID is held until ARREADY is sampled high. RREADY is asserted from issue. The transaction completes on RVALID & RREADY.
- The next command issues no earlier than the cycle after completion. At most one transaction is outstanding, and read and write never overlap.
- Addresses and data are stable while the corresponding VALID is high.
- evt_valid is high for the single cycle after CLR_WR completes. evt_status updates in that same cycle and holds until the next event.
- Reset mid-transaction: all outputs drop asynchronously, and the sequence restarts at INIT_0. The slave shares ARESETn.
- No timeout: a slave that never responds stalls the block with busy = 1.

## Structure
- Package zed_io_pkg holds:
  - register offset constants (0x00, 0x04, 0x08, 0x0C, 0x14, 0x20, 0x24, 0x28)
  - AXI response codes
  - the FSM state enum
- Sub-module axi_lite_mst_if is the single-transaction engine. It owns all AXI handshakes and the sticky response check.
  - Inputs: cmd_valid, cmd_we, cmd_addr, cmd_wdata.
  - Outputs: cmd_ready, done, rd_data, rsp_err.
- The top level contains the sequencing FSM and the output registers.

## Test plan
- Boot against the I/O register slave model → four writes observed: 0x24 = 0x0A, 0x20 = 0x1FFF, 0x14 = 0x1F1F, 0x0C = 0x1FFF. Then a read of 0x28, then init_done = 1 and err = 0.
- ID model returns 0x12345678 → err = 1, init_done stays 0, no further AXI traffic for 1000 cycles.
- After init, hold irq with status 0x0105 → read 0x08, write 0x08 = 0x105, evt_valid pulse, evt_status = 0x105.
- mirror_en = 1, switch = 0xA5, irq = 0 → read 0x04 then write 0x00 = 0x000000A5, repeated while mirror_en stays high.
- Random AWREADY, WREADY, ARREADY, BVALID and RVALID stalls of 0–7 cycles → VALID held stable until READY, and the write sequence order is unchanged.
- Slave returns DECERR on CLR_WR → err = 1, evt_valid still pulses, loop continues. ARESETn pulsed mid-write → all VALIDs drop immediately, and init restarts with the write to 0x24.

Source files
------------

// File: rtl/zed_io_pkg.sv
// rtl/zed_io_pkg.sv - shared constants and types for the board I/O sequencer
// Holds the I/O register offsets, AXI response codes and the sequencer state enum.
package zed_io_pkg;

    localparam logic [31:0] REG_LED      = 32'h0000_0000;
    localparam logic [31:0] REG_SW       = 32'h0000_0004;
    localparam logic [31:0] REG_INT_STS  = 32'h0000_0008;
    localparam logic [31:0] REG_INT_ENA  = 32'h0000_000C;
    localparam logic [31:0] REG_EDGE_SEL = 32'h0000_0014;
    localparam logic [31:0] REG_DEB_ENA  = 32'h0000_0020;
    localparam logic [31:0] REG_DEB_TIME = 32'h0000_0024;
    localparam logic [31:0] REG_ID       = 32'h0000_0028;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [3:0] {
        ST_INIT_0,
        ST_INIT_1,
        ST_INIT_2,
        ST_INIT_3,
        ST_ID_RD,
        ST_IDLE,
        ST_ST_RD,
        ST_CLR_WR,
        ST_SW_RD,
        ST_LED_WR,
        ST_FAIL
    } seq_state_e;

endpackage

// File: rtl/zed_io_seq_if.sv
// rtl/zed_io_seq_if.sv - AXI4-Lite bundle between the sequencer and the I/O register slave
// Carries the AW/W/B/AR/R channels; master drives VALIDs, addresses, write data and
// BREADY/RREADY, slave drives READYs, responses and read data.
interface zed_io_seq_if;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] AWADDR;
    logic        WVALID;
    logic        WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] ARADDR;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;

    modport master (
        output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axi_lite_mst_if.sv
// rtl/axi_lite_mst_if.sv - single-outstanding AXI4-Lite transaction engine
// Ports: ACLK/ARESETn; cmd_valid/cmd_we/cmd_addr/cmd_wdata in, cmd_ready out (accepts
// when idle); done pulses in the completion cycle with rd_data and done_err (non-OKAY
// response of that transaction); rsp_err is the sticky response error; axi is the bus.
module axi_lite_mst_if
    import zed_io_pkg::*;
(
    input  logic         ACLK,
    input  logic         ARESETn,
    input  logic         cmd_valid,
    input  logic         cmd_we,
    input  logic [31:0]  cmd_addr,
    input  logic [31:0]  cmd_wdata,
    output logic         cmd_ready,
    output logic         done,
    output logic [31:0]  rd_data,
    output logic         done_err,
    output logic         rsp_err,
    zed_io_seq_if.master axi
);

    logic        busy_q, busy_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        wr_done, rd_done;

    assign wr_done   = bready_q & axi.BVALID;
    assign rd_done   = rready_q & axi.RVALID;
    assign done      = wr_done | rd_done;
    assign done_err  = (wr_done && (axi.BRESP != RESP_OKAY)) ||
                       (rd_done && (axi.RRESP != RESP_OKAY));
    assign rd_data   = axi.RDATA;
    assign cmd_ready = ~busy_q;
    assign rsp_err   = rsp_err_q;

    assign axi.AWVALID = awvalid_q;
    assign axi.AWADDR  = addr_q;
    assign axi.WVALID  = wvalid_q;
    assign axi.WDATA   = wdata_q;
    assign axi.WSTRB   = 4'hF;
    assign axi.BREADY  = bready_q;
    assign axi.ARVALID = arvalid_q;
    assign axi.ARADDR  = addr_q;
    assign axi.RREADY  = rready_q;

    always_comb begin
        busy_d    = busy_q;
        awvalid_d = awvalid_q & ~axi.AWREADY;
        wvalid_d  = wvalid_q & ~axi.WREADY;
        arvalid_d = arvalid_q & ~axi.ARREADY;
        bready_d  = bready_q;
        rready_d  = rready_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rsp_err_d = rsp_err_q | (done & done_err);

        if (wr_done) begin
            bready_d = 1'b0;
            busy_d   = 1'b0;
        end
        if (rd_done) begin
            rready_d = 1'b0;
            busy_d   = 1'b0;
        end

        // Issue cannot coincide with a completion: completion needs busy_q set.
        if (cmd_valid && !busy_q) begin
            busy_d  = 1'b1;
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata;
            if (cmd_we) begin
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                bready_d  = 1'b1;
            end else begin
                arvalid_d = 1'b1;
                rready_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            busy_q    <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            rsp_err_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rsp_err_q <= rsp_err_d;
        end
    end

endmodule

// File: rtl/zed_io_seq.sv
// rtl/zed_io_seq.sv - autonomous AXI4-Lite master that boots and services the board I/O block
// Ports: ACLK/ARESETn; axi master bus; irq and mirror_en in; init_done, busy, err (sticky),
// evt_valid (one pulse per serviced interrupt) and evt_status (last status) out.
module zed_io_seq
    import zed_io_pkg::*;
#(
    parameter logic [4:0]  DEB_TIME = 5'd10,
    parameter logic [12:0] DEB_ENA  = 13'h1FFF,
    parameter logic [15:0] EDGE_CFG = 16'h1F1F,
    parameter logic [12:0] INT_ENA  = 13'h1FFF,
    parameter logic [31:0] ID_VALUE = 32'h7E8155AA
) (
    input  logic         ACLK,
    input  logic         ARESETn,
    zed_io_seq_if.master axi,
    input  logic         irq,
    input  logic         mirror_en,
    output logic         init_done,
    output logic         busy,
    output logic         err,
    output logic         evt_valid,
    output logic [12:0]  evt_status
);

    seq_state_e  state_q, state_d;
    logic        issued_q, issued_d;
    logic        init_done_q, init_done_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        evt_valid_q, evt_valid_d;
    logic [12:0] evt_status_q, evt_status_d;
    logic [12:0] status_q, status_d;
    logic [7:0]  sw_q, sw_d;

    logic        cmd_valid, cmd_we, cmd_ready, done, done_err, rsp_err;
    logic [31:0] cmd_addr, cmd_wdata, rd_data;

    axi_lite_mst_if u_mst (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .cmd_valid (cmd_valid),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_ready (cmd_ready),
        .done      (done),
        .rd_data   (rd_data),
        .done_err  (done_err),
        .rsp_err   (rsp_err),
        .axi       (axi)
    );

    assign init_done  = init_done_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign evt_valid  = evt_valid_q;
    assign evt_status = evt_status_q;

    always_comb begin
        state_d      = state_q;
        issued_d     = issued_q;
        init_done_d  = init_done_q;
        err_d        = err_q | rsp_err;
        evt_valid_d  = 1'b0;
        evt_status_d = evt_status_q;
        status_d     = status_q;
        sw_d         = sw_q;
        cmd_we       = 1'b0;
        cmd_addr     = 32'h0;
        cmd_wdata    = 32'h0;

        case (state_q)
            ST_INIT_0: begin cmd_we = 1'b1; cmd_addr = REG_DEB_TIME; cmd_wdata = {27'h0, DEB_TIME}; end
            ST_INIT_1: begin cmd_we = 1'b1; cmd_addr = REG_DEB_ENA;  cmd_wdata = {19'h0, DEB_ENA};  end
            ST_INIT_2: begin cmd_we = 1'b1; cmd_addr = REG_EDGE_SEL; cmd_wdata = {16'h0, EDGE_CFG}; end
            ST_INIT_3: begin cmd_we = 1'b1; cmd_addr = REG_INT_ENA;  cmd_wdata = {19'h0, INT_ENA};  end
            ST_ID_RD:  cmd_addr = REG_ID;
            ST_ST_RD:  cmd_addr = REG_INT_STS;
            ST_CLR_WR: begin cmd_we = 1'b1; cmd_addr = REG_INT_STS; cmd_wdata = {19'h0, status_q}; end
            ST_SW_RD:  cmd_addr = REG_SW;
            ST_LED_WR: begin cmd_we = 1'b1; cmd_addr = REG_LED; cmd_wdata = {24'h0, sw_q}; end
            default: ;
        endcase

        // Every state except IDLE and FAIL carries exactly one transaction.
        cmd_valid = (state_q != ST_IDLE) && (state_q != ST_FAIL) && !issued_q;
        if (cmd_valid && cmd_ready) begin
            issued_d = 1'b1;
        end

        if (done) begin
            issued_d = 1'b0;
            case (state_q)
                ST_INIT_0: state_d = ST_INIT_1;
                ST_INIT_1: state_d = ST_INIT_2;
                ST_INIT_2: state_d = ST_INIT_3;
                ST_INIT_3: state_d = ST_ID_RD;
                ST_ID_RD: begin
                    if (!done_err && (rd_data == ID_VALUE)) begin
                        init_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_FAIL;
                    end
                end
                ST_ST_RD: begin
                    status_d = rd_data[12:0];
                    state_d  = ST_CLR_WR;
                end
                ST_CLR_WR: begin
                    evt_valid_d  = 1'b1;
                    evt_status_d = status_q;
                    state_d      = ST_IDLE;
                end
                ST_SW_RD: begin
                    sw_d    = rd_data[7:0];
                    state_d = ST_LED_WR;
                end
                ST_LED_WR: state_d = ST_IDLE;
                default: ;
            endcase
        end

        // irq wins over the mirror step and is only looked at here.
        if (state_q == ST_IDLE) begin
            if (irq) begin
                state_d = ST_ST_RD;
            end else if (mirror_en) begin
                state_d = ST_SW_RD;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= ST_INIT_0;
            issued_q     <= 1'b0;
            init_done_q  <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            evt_valid_q  <= 1'b0;
            evt_status_q <= 13'h0;
            status_q     <= 13'h0;
            sw_q         <= 8'h0;
        end else begin
            state_q      <= state_d;
            issued_q     <= issued_d;
            init_done_q  <= init_done_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            evt_valid_q  <= evt_valid_d;
            evt_status_q <= evt_status_d;
            status_q     <= status_d;
            sw_q         <= sw_d;
        end
    end

endmodule

// File: tb/tb_zed_io_seq.sv
// tb/tb_zed_io_seq.sv - self-checking bench for zed_io_seq with an I/O register slave model
module tb_zed_io_seq;
    import zed_io_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b1;
    logic        irq = 1'b0;
    logic        mirror_en = 1'b0;
    logic        init_done, busy, err, evt_valid;
    logic [12:0] evt_status;

    zed_io_seq_if axi();

    zed_io_seq dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .axi        (axi),
        .irq        (irq),
        .mirror_en  (mirror_en),
        .init_done  (init_done),
        .busy       (busy),
        .err        (err),
        .evt_valid  (evt_valid),
        .evt_status (evt_status)
    );

    always #5 ACLK = ~ACLK;

    int n_chk = 0;
    int n_err = 0;
    logic [95:0] exp_q[$];

    // slave model state
    int          stall_max = 0;
    logic [12:0] sts = 13'h0;
    logic [7:0]  sw_val = 8'h0;
    logic [31:0] led_val = 32'h0;
    logic [31:0] id_val = 32'h7E8155AA;
    logic        decerr_clr = 1'b0;
    int          txn_cnt = 0, wr_cnt = 0, led_cnt = 0;
    logic        have_aw, have_w, have_ar;
    logic [31:0] waddr, wdat, raddr;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [31:0] aw_a, w_d, ar_a;

    // monitors
    int   evt_cnt = 0, evt_hi = 0, viol = 0;
    logic prev_ev = 1'b0;
    logic p_rst = 1'b0, p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_arv = 1'b0, p_arr = 1'b0;
    logic [31:0] p_awa, p_wd, p_ara;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] txn(input logic we, input logic [31:0] a, input logic [31:0] d);
        return {31'h0, we, a, d};
    endfunction

    function automatic int rnd();
        return int'($urandom_range(stall_max, 0));
    endfunction

    function automatic logic [31:0] reg_rd(input logic [31:0] a);
        case (a)
            REG_SW:      return {24'h0, sw_val};
            REG_INT_STS: return {19'h0, sts};
            REG_ID:      return id_val;
            default:     return 32'h0;
        endcase
    endfunction

    task automatic log_txn(input logic we, input logic [31:0] a, input logic [31:0] d);
        txn_cnt++;
        if (exp_q.size() == 0) chk("txn_unexpected", txn(we, a, d), '1);
        else                   chk("txn", txn(we, a, d), exp_q.pop_front());
    endtask

    task automatic push_boot();
        exp_q.push_back(txn(1'b1, 32'h24, 32'h0000000A));
        exp_q.push_back(txn(1'b1, 32'h20, 32'h00001FFF));
        exp_q.push_back(txn(1'b1, 32'h14, 32'h00001F1F));
        exp_q.push_back(txn(1'b1, 32'h0C, 32'h00001FFF));
        exp_q.push_back(txn(1'b0, 32'h28, 32'h0));
    endtask

    task automatic push_irq(input logic [12:0] s);
        exp_q.push_back(txn(1'b0, 32'h08, 32'h0));
        exp_q.push_back(txn(1'b1, 32'h08, {19'h0, s}));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge ACLK);
        #2;
    endtask

    task automatic wait_q_empty(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) wait_cycles(1);
        chk(tag, 96'(exp_q.size()), 96'd0);
    endtask

    task automatic wait_init(input string tag, input int budget);
        for (int i = 0; i < budget && !init_done; i++) wait_cycles(1);
        chk(tag, 96'(init_done), 96'd1);
    endtask

    // I/O register slave: samples handshakes at the edge, updates 1 time unit later.
    initial begin : slave
        axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = 1'b0; axi.BRESP = 2'b00;
        axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.RDATA = 32'h0; axi.RRESP = 2'b00;
        have_aw = 1'b0; have_w = 1'b0; have_ar = 1'b0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        forever begin
            @(posedge ACLK);
            aw_hs = axi.AWVALID & axi.AWREADY;
            w_hs  = axi.WVALID & axi.WREADY;
            b_hs  = axi.BVALID & axi.BREADY;
            ar_hs = axi.ARVALID & axi.ARREADY;
            r_hs  = axi.RVALID & axi.RREADY;
            aw_a = axi.AWADDR; w_d = axi.WDATA; ar_a = axi.ARADDR;
            #1;
            if (!ARESETn) begin
                axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = 1'b0;
                axi.ARREADY = 1'b0; axi.RVALID = 1'b0;
                have_aw = 1'b0; have_w = 1'b0; have_ar = 1'b0;
                aw_cnt = rnd(); w_cnt = rnd(); b_cnt = rnd(); ar_cnt = rnd(); r_cnt = rnd();
            end else begin
                if (aw_hs) begin have_aw = 1'b1; waddr = aw_a; axi.AWREADY = 1'b0; aw_cnt = rnd(); end
                if (w_hs)  begin have_w = 1'b1;  wdat = w_d;   axi.WREADY = 1'b0;  w_cnt = rnd();  end
                if (ar_hs) begin have_ar = 1'b1; raddr = ar_a; axi.ARREADY = 1'b0; ar_cnt = rnd(); end
                if (b_hs) axi.BVALID = 1'b0;
                if (r_hs) axi.RVALID = 1'b0;
                if (axi.AWVALID && !axi.AWREADY && !have_aw) begin
                    if (aw_cnt == 0) axi.AWREADY = 1'b1; else aw_cnt--;
                end
                if (axi.WVALID && !axi.WREADY && !have_w) begin
                    if (w_cnt == 0) axi.WREADY = 1'b1; else w_cnt--;
                end
                if (axi.ARVALID && !axi.ARREADY && !have_ar) begin
                    if (ar_cnt == 0) axi.ARREADY = 1'b1; else ar_cnt--;
                end
                if (have_aw && have_w && !axi.BVALID) begin
                    if (b_cnt == 0) begin
                        log_txn(1'b1, waddr, wdat);
                        axi.BRESP = (decerr_clr && waddr == REG_INT_STS) ? RESP_DECERR : RESP_OKAY;
                        if (waddr == REG_INT_STS) sts = sts & ~wdat[12:0];
                        if (waddr == REG_LED) begin led_val = wdat; led_cnt++; end
                        axi.BVALID = 1'b1;
                        have_aw = 1'b0; have_w = 1'b0;
                        wr_cnt++;
                        b_cnt = rnd();
                    end else b_cnt--;
                end
                if (have_ar && !axi.RVALID) begin
                    if (r_cnt == 0) begin
                        log_txn(1'b0, raddr, 32'h0);
                        axi.RDATA  = reg_rd(raddr);
                        axi.RRESP  = RESP_OKAY;
                        axi.RVALID = 1'b1;
                        have_ar = 1'b0;
                        r_cnt = rnd();
                    end else r_cnt--;
                end
            end
            irq = (sts != 13'h0);
        end
    end

    always @(negedge ACLK) begin
        if (evt_valid) evt_hi++;
        if (evt_valid && !prev_ev) evt_cnt++;
        prev_ev = evt_valid;
    end

    // Protocol watch: VALID held with stable payload until READY; no read/write overlap.
    always @(posedge ACLK) begin
        if (ARESETn && p_rst) begin
            if (p_awv && !p_awr && (!axi.AWVALID || axi.AWADDR != p_awa)) viol++;
            if (p_wv && !p_wr && (!axi.WVALID || axi.WDATA != p_wd)) viol++;
            if (p_arv && !p_arr && (!axi.ARVALID || axi.ARADDR != p_ara)) viol++;
            if ((axi.AWVALID | axi.WVALID | axi.BREADY) && (axi.ARVALID | axi.RREADY)) viol++;
        end
        p_rst = ARESETn;
        p_awv = axi.AWVALID; p_awr = axi.AWREADY; p_awa = axi.AWADDR;
        p_wv  = axi.WVALID;  p_wr  = axi.WREADY;  p_wd  = axi.WDATA;
        p_arv = axi.ARVALID; p_arr = axi.ARREADY; p_ara = axi.ARADDR;
    end

    initial begin : stim
        int base;
        #1 ARESETn = 1'b0;
        wait_cycles(3);
        chk("rst_awvalid", 96'(axi.AWVALID), 96'd0);
        chk("rst_wvalid", 96'(axi.WVALID), 96'd0);
        chk("rst_arvalid", 96'(axi.ARVALID), 96'd0);
        chk("rst_bready_rready", 96'({axi.BREADY, axi.RREADY}), 96'd0);
        chk("rst_wstrb", 96'(axi.WSTRB), 96'hF);
        chk("rst_flags", 96'({init_done, busy, err, evt_valid}), 96'd0);
        chk("rst_evt_status", 96'(evt_status), 96'd0);

        // boot
        push_boot();
        ARESETn = 1'b1;
        wait_init("boot_init_done", 300);
        chk("boot_q", 96'(exp_q.size()), 96'd0);
        chk("boot_err", 96'(err), 96'd0);
        chk("boot_busy_idle", 96'(busy), 96'd0);

        // interrupt service
        push_irq(13'h105);
        sts = 13'h105;
        wait_q_empty("irq_q", 200);
        wait_cycles(5);
        chk("irq_evt_cnt", 96'(evt_cnt), 96'd1);
        chk("irq_evt_hi", 96'(evt_hi), 96'd1);
        chk("irq_evt_status", 96'(evt_status), 96'h105);
        chk("irq_err", 96'(err), 96'd0);

        // switch-to-LED mirror, three rounds
        sw_val = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(txn(1'b0, 32'h04, 32'h0));
            exp_q.push_back(txn(1'b1, 32'h00, 32'h000000A5));
        end
        base = led_cnt;
        mirror_en = 1'b1;
        for (int i = 0; i < 300 && led_cnt < base + 3; i++) wait_cycles(1);
        mirror_en = 1'b0;
        wait_cycles(20);
        chk("mirror_led_cnt", 96'(led_cnt - base), 96'd3);
        chk("mirror_q", 96'(exp_q.size()), 96'd0);

        // DECERR on the clear write, then one more ordinary interrupt
        decerr_clr = 1'b1;
        push_irq(13'h003);
        sts = 13'h003;
        wait_q_empty("decerr_q", 200);
        wait_cycles(5);
        chk("decerr_err", 96'(err), 96'd1);
        chk("decerr_evt_cnt", 96'(evt_cnt), 96'd2);
        chk("decerr_evt_status", 96'(evt_status), 96'h003);
        decerr_clr = 1'b0;
        push_irq(13'h010);
        sts = 13'h010;
        wait_q_empty("after_decerr_q", 200);
        wait_cycles(5);
        chk("after_decerr_evt_cnt", 96'(evt_cnt), 96'd3);
        chk("after_decerr_status", 96'(evt_status), 96'h010);
        chk("err_sticky", 96'(err), 96'd1);

        // random stalls plus reset in the middle of the second init write
        stall_max = 7;
        ARESETn = 1'b0;
        wait_cycles(3);
        exp_q.delete();
        push_boot();
        base = wr_cnt;
        ARESETn = 1'b1;
        for (int i = 0; i < 300 && wr_cnt == base; i++) wait_cycles(1);
        chk("midrst_first_write", 96'(wr_cnt - base), 96'd1);
        for (int i = 0; i < 100; i++) begin
            @(posedge ACLK);
            #3;
            if (axi.AWVALID) break;
        end
        chk("midrst_awvalid_seen", 96'(axi.AWVALID), 96'd1);
        ARESETn = 1'b0;
        #1;
        chk("midrst_valids_drop", 96'({axi.AWVALID, axi.WVALID, axi.ARVALID, axi.BREADY}), 96'd0);
        chk("midrst_flags", 96'({init_done, busy, err}), 96'd0);
        wait_cycles(3);
        exp_q.delete();
        push_boot();
        ARESETn = 1'b1;
        wait_init("stall_boot_init_done", 800);
        chk("stall_boot_q", 96'(exp_q.size()), 96'd0);
        chk("stall_boot_err", 96'(err), 96'd0);

        // wrong ID: terminal FAIL, no more bus traffic
        stall_max = 0;
        ARESETn = 1'b0;
        wait_cycles(3);
        exp_q.delete();
        id_val = 32'h12345678;
        push_boot();
        ARESETn = 1'b1;
        wait_q_empty("idfail_q", 300);
        wait_cycles(5);
        chk("idfail_err", 96'(err), 96'd1);
        chk("idfail_init_done", 96'(init_done), 96'd0);
        chk("idfail_busy", 96'(busy), 96'd1);
        base = txn_cnt;
        wait_cycles(1000);
        chk("idfail_quiet", 96'(txn_cnt), 96'(base));
        chk("idfail_no_valid", 96'({axi.AWVALID, axi.ARVALID}), 96'd0);

        chk("protocol_violations", 96'(viol), 96'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
